udp_frame_builder: RTL and testbench

Builds one UDP datagram per command: reads N payload words from the datapath data memory read port, computes the UDP checksum over the pseudo-header, header and payload, then streams the header plus payload as 32-bit AXI-Stream beats. Sits directly downstream of the Datapath IP data memory, which is filled over AXI4-Lite, and feeds the IP/MAC transmit path.

---
 rtl/udp_frame_builder.sv | 161 ++++++++++++++++
 tb/tb_udp_frame_builder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/udp_frame_builder.sv
// udp_frame_builder: one UDP datagram per start (cmd/ips/ports in, mem_addr/mem_rdata read port, checksummed AXI-Stream frame out, busy/done/err status)
module udp_frame_builder #(
    parameter int ADDR_WIDTH = 6,
    parameter int MAX_WORDS = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len_words,
    input  logic [31:0]           src_ip,
    input  logic [31:0]           dst_ip,
    input  logic [15:0]           src_port,
    input  logic [15:0]           dst_port,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_rdata,
    output logic [31:0]           m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam logic [ADDR_WIDTH:0] MAXW = (ADDR_WIDTH + 1)'(MAX_WORDS);
    typedef enum logic [2:0] {IDLE, SUM, FOLD, HDR0, HDR1, PAYLOAD} state_t;
    state_t state;
    logic [ADDR_WIDTH:0] n, c, rd, sent;
    logic [15:0] sp, dp, csum, l, l_in, cs;
    logic [23:0] acc, acc_init;
    logic [31:0] b0, b1, word;
    logic [1:0] bc, nb;
    logic [2:0] occ;
    logic v1, v2, avail, take, pop, from_buf, push, issue, prefetch;
    always_comb begin
        l = 16'd8 + 16'({n, 2'b00});
        l_in = 16'd8 + 16'({len_words, 2'b00});
        acc_init = 24'(src_ip[31:16]) + 24'(src_ip[15:0]) + 24'(dst_ip[31:16]) + 24'(dst_ip[15:0])
            + 24'h000011 + 24'(l_in) + 24'(l_in) + 24'(src_port) + 24'(dst_port);
        cs = ~acc[15:0];
        avail = bc != 2'd0 || v2;
        word = bc != 2'd0 ? b0 : mem_rdata;
        take = state == HDR1 ? m_axis_tready
             : state == PAYLOAD && (!m_axis_tvalid || m_axis_tready) && !(m_axis_tvalid && m_axis_tlast);
        pop = take && avail;
        from_buf = pop && bc != 2'd0;
        push = v2 && !(pop && bc == 2'd0);
        nb = bc - 2'(from_buf);
        occ = 3'(bc) + 3'(v1) + 3'(v2) - 3'(pop);
        prefetch = state == FOLD || state == HDR0 || state == HDR1 || state == PAYLOAD;
        issue = prefetch && rd < n && occ < 3'd2;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            m_axis_tdata <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast <= 1'b0;
            mem_addr <= '0;
            acc <= '0;
            csum <= '0;
            b0 <= '0;
            b1 <= '0;
            bc <= '0;
            v1 <= 1'b0;
            v2 <= 1'b0;
            n <= '0;
            c <= '0;
            rd <= '0;
            sent <= '0;
            sp <= '0;
            dp <= '0;
        end else begin
            done <= 1'b0;
            err <= 1'b0;
            v1 <= issue;
            v2 <= v1;
            b0 <= push && nb == 2'd0 ? mem_rdata : from_buf ? b1 : b0;
            b1 <= push && nb == 2'd1 ? mem_rdata : b1;
            bc <= nb + 2'(push);
            if (issue) begin
                mem_addr <= rd[ADDR_WIDTH-1:0];
                rd <= rd + 1'b1;
            end
            if (pop) begin
                m_axis_tdata <= word;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast <= sent + 1'b1 == n;
                sent <= sent + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start && len_words > MAXW) err <= 1'b1;
                    else if (start) begin
                        busy <= 1'b1;
                        n <= len_words;
                        sp <= src_port;
                        dp <= dst_port;
                        acc <= acc_init;
                        c <= '0;
                        rd <= '0;
                        sent <= '0;
                        mem_addr <= '0;
                        state <= SUM;
                    end
                end
                SUM: begin
                    c <= c + 1'b1;
                    if (c + 1'b1 < n) mem_addr <= ADDR_WIDTH'(c + 1'b1);
                    if (c != '0) acc <= acc + 24'(mem_rdata[31:16]) + 24'(mem_rdata[15:0]);
                    if (c == n) begin
                        c <= '0;
                        state <= FOLD;
                    end
                end
                FOLD: begin
                    c <= c + 1'b1;
                    acc <= 24'(acc[15:0]) + 24'(acc[23:16]);
                    if (c[1:0] == 2'd2) begin
                        csum <= cs == 16'd0 ? 16'hFFFF : cs;
                        m_axis_tdata <= {sp, dp};
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast <= 1'b0;
                        state <= HDR0;
                    end
                end
                HDR0: begin
                    if (m_axis_tready) begin
                        m_axis_tdata <= {l, csum};
                        m_axis_tlast <= n == '0;
                        state <= HDR1;
                    end
                end
                HDR1: begin
                    if (m_axis_tready && n == '0) begin
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast <= 1'b0;
                        done <= 1'b1;
                        busy <= 1'b0;
                        state <= IDLE;
                    end else if (m_axis_tready) begin
                        state <= PAYLOAD;
                        if (!pop) m_axis_tvalid <= 1'b0;
                    end
                end
                PAYLOAD: begin
                    if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast <= 1'b0;
                        done <= 1'b1;
                        busy <= 1'b0;
                        state <= IDLE;
                    end else if (m_axis_tready && !pop) m_axis_tvalid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_udp_frame_builder.sv
// tb_udp_frame_builder: directed frames with a beat scoreboard and a decoupled output monitor
module tb_udp_frame_builder;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [6:0] len_words = '0;
    logic [31:0] src_ip = 32'hC0A80001;
    logic [31:0] dst_ip = 32'hC0A80002;
    logic [15:0] src_port = 16'h1234;
    logic [15:0] dst_port = 16'h5678;
    logic [5:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic [31:0] m_axis_tdata;
    logic m_axis_tvalid, m_axis_tlast, busy, done, err;
    logic m_axis_tready = 1'b1;
    logic [31:0] mem [64];
    logic [32:0] q[$];
    logic [32:0] held, exp_beat;
    logic stall = 1'b0;
    int checks = 0, failures = 0, cyc = 0, rmode = 0, frame_beats = 0, first_cyc = 0, last_cyc = 0;

    udp_frame_builder dut (
        .clock(clock), .reset(reset), .start(start), .len_words(len_words),
        .src_ip(src_ip), .dst_ip(dst_ip), .src_port(src_port), .dst_port(dst_port),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready), .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        mem_rdata <= mem[mem_addr];
        cyc <= cyc + 1;
    end

    initial forever begin
        @(posedge clock);
        #1;
        m_axis_tready = rmode == 0 ? 1'b1 : ~m_axis_tready;
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    always @(negedge clock) begin
        if (reset) stall = 1'b0;
        else begin
            if (stall) chk("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, held});
            stall = m_axis_tvalid && !m_axis_tready;
            held = {m_axis_tlast, m_axis_tdata};
            if (m_axis_tvalid && m_axis_tready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%h required=none", {m_axis_tlast, m_axis_tdata});
                end else begin
                    exp_beat = q.pop_front();
                    chk("beat", {m_axis_tlast, m_axis_tdata}, exp_beat);
                    if (frame_beats == 0) first_cyc = cyc;
                    if (m_axis_tlast) last_cyc = cyc;
                    frame_beats++;
                end
            end
        end
    end

    task automatic send(input int len, input logic [31:0] hdr1, input int rm, input bit tp, input bit poke);
        int k;
        q.push_back({1'b0, 32'h12345678});
        q.push_back({len == 0, hdr1});
        for (int i = 0; i < len; i++) q.push_back({i == len - 1, 32'(i + 1)});
        rmode = rm;
        frame_beats = 0;
        start = 1'b1;
        len_words = 7'(len);
        @(negedge clock);
        start = 1'b0;
        k = 0;
        while (!m_axis_tvalid && k < 100) begin
            @(negedge clock);
            k++;
        end
        chk("latency", 64'(k), 64'(len + 4));
        if (poke) begin
            start = 1'b1;
            len_words = 7'd1;
            @(negedge clock);
            start = 1'b0;
            chk("busy_start_err", {63'd0, err}, 64'd0);
            chk("busy_start_busy", {63'd0, busy}, 64'd1);
        end
        k = 0;
        while (!done && k < 400) begin
            @(negedge clock);
            k++;
        end
        chk("done_seen", {63'd0, done}, 64'd1);
        chk("done_timing", 64'(cyc), 64'(last_cyc + 1));
        chk("busy_at_done", {63'd0, busy}, 64'd0);
        chk("beat_count", 64'(frame_beats), 64'(len + 2));
        if (tp) chk("throughput", 64'(last_cyc - first_cyc), 64'(len + 1));
        chk("queue_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int k;
        logic seen;
        for (int i = 0; i < 64; i++) mem[i] = 32'hA5A50000 | 32'(i);
        for (int i = 0; i < 4; i++) mem[i] = 32'(i + 1);
        repeat (3) @(negedge clock);
        chk("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("rst_outs", {58'd0, m_axis_tlast, busy, done, err, 2'd0}, 64'd0);
        chk("rst_tdata", {32'd0, m_axis_tdata}, 64'd0);
        chk("rst_addr", {58'd0, mem_addr}, 64'd0);
        reset = 1'b0;
        @(negedge clock);
        send(1, 32'h000C15D5, 0, 1'b1, 1'b0);
        send(4, 32'h001815B4, 0, 1'b1, 1'b0);
        send(4, 32'h001815B4, 1, 1'b0, 1'b1);
        send(0, 32'h000815DE, 0, 1'b1, 1'b0);
        chk("len0_addr", {58'd0, mem_addr}, 64'd0);
        rmode = 0;
        start = 1'b1;
        len_words = 7'd65;
        @(negedge clock);
        start = 1'b0;
        chk("err_pulse", {63'd0, err}, 64'd1);
        chk("err_busy", {63'd0, busy}, 64'd0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clock);
            seen = seen | m_axis_tvalid | busy | err | done;
        end
        chk("err_quiet", {63'd0, seen}, 64'd0);
        q.push_back({1'b0, 32'h12345678});
        q.push_back({1'b0, 32'h001815B4});
        for (int i = 0; i < 4; i++) q.push_back({i == 3, 32'(i + 1)});
        start = 1'b1;
        len_words = 7'd4;
        @(negedge clock);
        start = 1'b0;
        k = 0;
        while (!(m_axis_tvalid && m_axis_tdata == 32'd2) && k < 100) begin
            @(negedge clock);
            k++;
        end
        chk("mid_payload_reached", {63'd0, m_axis_tvalid}, 64'd1);
        reset = 1'b1;
        q.delete();
        @(negedge clock);
        chk("mid_rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("mid_rst_outs", {58'd0, m_axis_tlast, busy, done, err, 2'd0}, 64'd0);
        chk("mid_rst_tdata", {32'd0, m_axis_tdata}, 64'd0);
        chk("mid_rst_addr", {58'd0, mem_addr}, 64'd0);
        reset = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clock);
            seen = seen | m_axis_tvalid | done | busy;
        end
        chk("post_rst_quiet", {63'd0, seen}, 64'd0);
        send(1, 32'h000C15D5, 0, 1'b1, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
